// File: rtl/program_loader_if.sv
// Stream-in / memory-write bundle for program_loader.
// The loader takes the slave modport; the stream source and memory side take the master modport.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_valid may drop at any time. in_ready is registered and depends only on loader state.
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed byte image into program memory from address 0 and holds cpu_reset until done.
// Define PROGRAM_LOADER_CSUM_EN to expect a trailing checksum byte (payload + csum == 0 mod 256).
module program_loader #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  program_loader_if.slave bus,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] byte_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MEM_DEPTH);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic        accept;
  logic [15:0] len_in;

  assign accept    = bus.in_valid && bus.in_ready;
  assign len_in    = {bus.in_data, len_lo};
  assign state_dbg = state;

`ifdef PROGRAM_LOADER_CSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  assign sum_next = sum + bus.in_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_LEN_LO;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_reset     <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      byte_count    <= '0;
      len_lo        <= '0;
      len           <= '0;
`ifdef PROGRAM_LOADER_CSUM_EN
      sum           <= '0;
`endif
    end else begin
      bus.mem_we   <= 1'b0;
      bus.in_ready <= (state != S_DONE) && (state != S_ERR);
      if (accept) begin
        case (state)
          S_LEN_LO: begin
            len_lo <= bus.in_data;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len <= len_in;
            if ({1'b0, len_in} > MAX_LEN) begin
              state        <= S_ERR;
              load_err     <= 1'b1;
              bus.in_ready <= 1'b0;
            end else if (len_in == 16'd0) begin
`ifdef PROGRAM_LOADER_CSUM_EN
              state        <= S_CSUM;
`else
              state        <= S_DONE;
              load_done    <= 1'b1;
              cpu_reset    <= 1'b0;
              bus.in_ready <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            // Length check upstream keeps byte_count below MEM_DEPTH here.
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= byte_count[ADDR_W-1:0];
            bus.mem_wdata <= bus.in_data;
            byte_count    <= byte_count + 16'd1;
`ifdef PROGRAM_LOADER_CSUM_EN
            sum           <= sum_next;
            if (byte_count + 16'd1 == len) state <= S_CSUM;
`else
            if (byte_count + 16'd1 == len) begin
              state        <= S_DONE;
              load_done    <= 1'b1;
              cpu_reset    <= 1'b0;
              bus.in_ready <= 1'b0;
            end
`endif
          end
`ifdef PROGRAM_LOADER_CSUM_EN
          S_CSUM: begin
            bus.in_ready <= 1'b0;
            if (sum_next == 8'd0) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: driver issues streams and queues expected writes,
// a negedge monitor pops and compares every mem_we beat.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int ADDR_W = 8;
`ifdef PROGRAM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;
  logic [15:0] byte_count;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  stim_q[$];

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .byte_count (byte_count),
    .state_dbg  (state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [15:0] exp;
        exp = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== exp) begin
          errors++;
          $display("FAIL mem_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   bus.mem_addr, bus.mem_wdata, exp[15:8], exp[7:0]);
        end
      end
    end
  end

  // Driver tasks (all called at a negedge)
  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready",   bus.in_ready,   0);
    check("rst_mem_we",     bus.mem_we,     0);
    check("rst_mem_addr",   bus.mem_addr,   0);
    check("rst_mem_wdata",  bus.mem_wdata,  0);
    check("rst_cpu_reset",  cpu_reset,      1);
    check("rst_load_done",  load_done,      0);
    check("rst_load_err",   load_err,       0);
    check("rst_byte_count", byte_count,     0);
    check("rst_state",      state_dbg,      0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
  endtask

  task automatic send_stream(input int gap, input int n_pay, input bit exp_term);
    for (int i = 0; i < stim_q.size(); i++) begin
      bit pay;
      int waited;
      pay          = (i >= 2) && (i < 2 + n_pay);
      waited       = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = stim_q[i];
      while (bus.in_ready !== 1'b1 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (bus.in_ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: in_ready stayed low at stream byte %0d", i);
        bus.in_valid = 1'b0;
        return;
      end
      if (pay) exp_q.push_back({8'(i - 2), stim_q[i]});
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (pay) check("write_latency", bus.mem_we, 1);
      if (i == stim_q.size() - 1 && exp_term)
        check("terminal_edge", load_done | load_err, 1);
      else
        check("cpu_reset_held", cpu_reset, 1);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic check_end(input bit e_done, input bit e_err, input logic [15:0] e_count);
    repeat (2) @(negedge clk);
    check("load_done",  load_done,     e_done);
    check("load_err",   load_err,      e_err);
    check("cpu_reset",  cpu_reset,     !e_done);
    check("byte_count", byte_count,    e_count);
    check("in_ready",   bus.in_ready,  0);
    check("pending_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_good3();
    stim_q = '{8'h03, 8'h00, 8'h6A, 8'h05, 8'h8B};
    if (CSUM) stim_q.push_back(8'h06);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);

    // Bad checksum (macro on) / plain 3-byte load (macro off)
    do_reset();
    stim_q = '{8'h03, 8'h00, 8'h6A, 8'h05, 8'h8B};
    if (CSUM) stim_q.push_back(8'hB9);
    send_stream(0, 3, 1'b1);
    check_end(!CSUM, CSUM, 16'd3);

    // Good 3-byte load, then bytes offered in DONE are refused
    do_reset();
    load_good3();
    send_stream(0, 3, 1'b1);
    check_end(1'b1, 1'b0, 16'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hB9;
    repeat (3) begin
      @(negedge clk);
      check("done_refuses", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    check("done_count_stable", byte_count, 16'd3);

    // Oversize length 257
    do_reset();
    stim_q = '{8'h01, 8'h01};
    send_stream(0, 0, 1'b1);
    check_end(1'b0, 1'b1, 16'd0);

    // Zero length
    do_reset();
    stim_q = '{8'h00, 8'h00};
    if (CSUM) stim_q.push_back(8'h00);
    send_stream(0, 0, 1'b1);
    check_end(1'b1, 1'b0, 16'd0);

    // Throttled in_valid
    do_reset();
    load_good3();
    send_stream(1, 3, 1'b1);
    check_end(1'b1, 1'b0, 16'd3);

    // Reset mid-DATA after two bytes, then a fresh image
    do_reset();
    stim_q = '{8'h03, 8'h00, 8'h11, 8'h22};
    send_stream(0, 3, 1'b0);
    do_reset();
    stim_q = '{8'h02, 8'h00, 8'hAA, 8'h56};
    if (CSUM) stim_q.push_back(8'h00);
    send_stream(0, 2, 1'b1);
    check_end(1'b1, 1'b0, 16'd2);

    // Full-depth image: N = 256, byte i at address i; payload sum is 0x80 mod 256
    do_reset();
    stim_q = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) stim_q.push_back(8'(i));
    if (CSUM) stim_q.push_back(8'h80);
    send_stream(0, 256, 1'b1);
    check_end(1'b1, 1'b0, 16'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream writer that fills the program memory the `fetch` stage later reads. It accepts a length-prefixed x86 byte image over a valid/ready handshake and writes each payload byte to consecutive byte addresses from 0. It holds the CPU in reset (`cpu_reset`) until the image has been written, then releases it. It sits between the test/host stream source and the memory write port, ahead of `cpu_clock` / `fetch` in reset sequencing.

## Interface
Parameters:
- `ADDR_W`, 8: memory byte-address width.
- `MEM_DEPTH`, 256: usable bytes; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  stream byte valid.
- `in_ready`  out  1  loader can accept a byte.
- `in_data`  in  8  stream byte.
- `mem_we`  out  1  one-cycle write strobe to program memory.
- `mem_addr`  out  ADDR_W  write byte address.
- `mem_wdata`  out  8  write data.
- `cpu_reset`  out  1  reset for `cpu_clock`, `fetch` and the rest of the core; high until the load completes.
- `load_done`  out  1  image written successfully (sticky).
- `load_err`  out  1  load aborted (sticky).
- `byte_count`  out  16  payload bytes written so far.

## Operation
- A beat is accepted on a rising edge with `in_valid && in_ready`.
- Stream format: LEN_LO, LEN_HI (16-bit little-endian payload length N), then N payload bytes, then one checksum byte when `PROGRAM_LOADER_CSUM_EN` is defined.
- FSM states: LEN_LO → LEN_HI → DATA → CSUM → DONE, plus ERR.
  - LEN_LO: latch low length byte.
  - LEN_HI: latch high byte. Goes to ERR if N > MEM_DEPTH. If N = 0, skips to CSUM (or to DONE when the macro is off). Otherwise goes to DATA.
  - DATA: each accepted byte is written to address `byte_count[ADDR_W-1:0]`. `byte_count` is then incremented. After the Nth byte, goes to CSUM or DONE.
  - CSUM: goes to DONE if (sum of payload + checksum byte) mod 256 = 0, otherwise to ERR.
  - DONE / ERR: terminal. Only `reset` leaves them.
- `in_ready` = 1 in LEN_LO, LEN_HI, DATA, CSUM. `in_ready` = 0 in DONE and ERR.
- Running sum: 8-bit, wraps modulo 256. It covers payload bytes only; length bytes are excluded.
- Address never wraps: the N ≤ MEM_DEPTH check guarantees `byte_count` < MEM_DEPTH at every write.
- `cpu_reset` stays high in every state except DONE. It never deasserts in ERR.

## Timing
- Reset values: state = LEN_LO, `in_ready` = 0 during the reset cycle and 1 on the first cycle after, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_reset` = 1, `load_done` = 0, `load_err` = 0, `byte_count` = 0, sum = 0.
- Write latency is 1 cycle. A payload byte accepted at edge k produces `mem_we` = 1 with registered addr/data during cycle k+1. Back-to-back beats produce back-to-back writes.
- `in_valid` may drop at any time. No byte is lost or duplicated while it is low.
- The last write, `load_done` = 1 and `cpu_reset` = 0 are all registered on the same edge. Memory therefore sees the final write in the same cycle that reset releases. `fetch` does not run until `cpu_clock` phase 1, which comes at least one cycle later.
- `load_err` rises on the edge that leaves LEN_HI or CSUM toward ERR. No `mem_we` occurs after that edge.
- `reset` asserted mid-load returns the block to the reset values on the next edge. Written memory contents are not cleared, and a new image overwrites them.
- Bytes presented in DONE/ERR are not accepted (`in_ready` = 0).

## Configuration
- `PROGRAM_LOADER_CSUM_EN` defined: the CSUM state and the checksum byte are expected, and a mismatch goes to ERR.
- Macro undefined: there is no checksum byte and no sum register. DATA (or LEN_HI with N = 0) goes directly to DONE, and `load_err` can only result from an oversize length.

## Test plan
- Macro on. Stream 03 00 6A 05 8B B9 (0x6A+0x05+0x8B = 0xFA; 0xFA+0xB9 = 0x1B3, low byte ≠ 0, so ERR). Expect writes 0:6A, 1:05, 2:8B, then `load_err` = 1, `cpu_reset` stays 1.
- Macro on. Stream 03 00 6A 05 8B 06 (sum 0x100 → 0x00). Expect 3 writes on consecutive cycles, `load_done` = 1, `cpu_reset` = 0 on the edge after the checksum beat, `byte_count` = 3.
- Oversize: with MEM_DEPTH = 256, stream 01 01 (N = 257). Expect ERR after LEN_HI, no `mem_we`, `in_ready` = 0.
- N = 0 with the macro on: stream 00 00 00. Expect DONE with no writes. With the macro off, stream 00 00 → DONE.
- Throttling: same stream as the second scenario, with `in_valid` toggled 1-0-1-0. Expect identical writes, each exactly once, with `mem_we` 1 cycle after each accepted beat.
- Reset mid-DATA after 2 bytes: expect reset values next cycle and `cpu_reset` = 1. A fresh 02 00 AA 56 (sum 0x100) then loads, reaching DONE with 0:AA, 1:56.
